// File: rtl/ntt_barrett_modmul_pkg.sv
// Shared types and width helpers for the NTT Barrett twiddle multiplier and
// its mu divider.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif

package ntt_barrett_modmul_pkg;

    typedef enum logic [1:0] {
        StUncfg,
        StCalc,
        StReady
    } state_e;

    // Input handshake to out_valid, in cycles, with out_ready held high.
    localparam int unsigned PIPE_LAT = 4;

    // Barrett constant width (MUW = 2W).
    function automatic int unsigned mu_width(input int unsigned w);
        return 2 * w;
    endfunction

    // Width of the partially reduced remainder (RW = W+2, holds r < 3q).
    function automatic int unsigned r_width(input int unsigned w);
        return w + 2;
    endfunction

endpackage

// File: rtl/ntt_barrett_modmul_mu_div.sv
// Sequential restoring divider producing mu = floor(2^(2W) / q), one quotient
// bit per cycle over 2W+1 cycles.
module barrett_mu_div
    import ntt_barrett_modmul_pkg::*;
#(
    parameter int unsigned W = `DATA_SIZE_ARB
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   q,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] mu
);
    localparam int unsigned MUW = mu_width(W);
    localparam int unsigned CW  = $clog2(MUW + 1);

    logic           busy_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   rem_q;
    logic [MUW-2:0] quo_q;
    logic [MUW-1:0] mu_q;

    logic [W:0]     rem_sh;
    logic [W:0]     rem_sub;
    logic           qbit;

    // The dividend 2^(2W) is a single 1 followed by 2W zeros, fed MSB first.
    always_comb begin
        rem_sh  = {rem_q, (cnt_q == '0)};
        rem_sub = rem_sh - {1'b0, q};
        qbit    = (rem_sh >= {1'b0, q});
    end

    assign done = busy_q && (cnt_q == CW'(MUW));
    assign busy = busy_q;
    assign mu   = mu_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            mu_q   <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
        end else if (busy_q) begin
            rem_q <= qbit ? W'(rem_sub) : W'(rem_sh);
            quo_q <= (MUW-1)'({quo_q, qbit});
            cnt_q <= cnt_q + CW'(1);
            // The first quotient bit is always 0 (q >= 2), so it falls off the top.
            if (done) begin
                busy_q <= 1'b0;
                mu_q   <= {quo_q, qbit};
            end
        end
    end

endmodule

// File: rtl/ntt_barrett_modmul.sv
// Pipelined Barrett modular multiplier: out_data = (in_a * in_w) mod q, with the
// even butterfly operand carried alongside so both reach the add/sub stage aligned.
module ntt_barrett_modmul
    import ntt_barrett_modmul_pkg::*;
#(
    parameter int unsigned W   = `DATA_SIZE_ARB,
    parameter int unsigned PW  = `DATA_SIZE_ARB,
    parameter int unsigned LAT = PIPE_LAT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_load,
    input  logic [W-1:0]  cfg_q,
    output logic          cfg_busy,
    output logic          cfg_err,
    output logic          cfg_ready,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_w,
    input  logic [PW-1:0] in_pass,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [PW-1:0] out_pass
);
    localparam int unsigned MUW = mu_width(W);
    localparam int unsigned RW  = r_width(W);
    localparam int unsigned XMW = 2 * MUW;
    localparam int unsigned TQW = MUW + W;

    state_e         state_q;
    logic           cfg_err_q;
    logic           cfg_ready_q;
    logic [W-1:0]   mod_q;
    logic [MUW-1:0] mu_val;
    logic           div_busy;
    logic           div_done;

    logic [LAT-1:0] vld_q;
    logic [MUW-1:0] x1_q, x2_q, t2_q;
    logic [RW-1:0]  r3_q;
    logic [W-1:0]   data_q;
    logic [PW-1:0]  p1_q, p2_q, p3_q, pass_q;

    logic           advance;
    logic           pipe_empty;
    logic           cfg_ok;
    logic           fire;

    logic [XMW-1:0] xmu;
    logic [TQW-1:0] tq;
    logic [TQW-1:0] diff;
    logic [RW-1:0]  q_ext;
    logic [RW-1:0]  red1;
    logic [RW-1:0]  red2;

    barrett_mu_div #(
        .W (W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (cfg_ok),
        .q     (mod_q),
        .busy  (div_busy),
        .done  (div_done),
        .mu    (mu_val)
    );

    always_comb begin
        advance    = !vld_q[LAT-1] || out_ready;
        pipe_empty = (vld_q == '0);
        cfg_ok     = cfg_load && (state_q != StCalc) && pipe_empty && (cfg_q >= W'(2));
        // An accepted load takes priority over an operand offered in the same cycle.
        in_ready   = (state_q == StReady) && advance && !cfg_ok;
        fire       = in_valid && in_ready;
    end

    always_comb begin
        xmu   = XMW'(x1_q) * XMW'(mu_val);
        tq    = TQW'(t2_q) * TQW'(mod_q);
        diff  = TQW'(x2_q) - tq;
        q_ext = RW'(mod_q);
        red1  = (r3_q >= q_ext) ? (r3_q - q_ext) : r3_q;
        red2  = (red1 >= q_ext) ? (red1 - q_ext) : red1;
    end

    assign cfg_busy  = div_busy;
    assign cfg_err   = cfg_err_q;
    assign cfg_ready = cfg_ready_q;
    assign out_valid = vld_q[LAT-1];
    assign out_data  = data_q;
    assign out_pass  = pass_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StUncfg;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            mod_q       <= '0;
        end else begin
            cfg_err_q <= cfg_load && !cfg_ok;
            case (state_q)
                StUncfg, StReady: begin
                    if (cfg_ok) begin
                        state_q     <= StCalc;
                        mod_q       <= cfg_q;
                        cfg_ready_q <= 1'b0;
                    end
                end
                StCalc: begin
                    if (div_done) begin
                        state_q     <= StReady;
                        cfg_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StUncfg;
                    cfg_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Whole pipeline moves in lockstep; bubbles travel with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q  <= '0;
            x1_q   <= '0;
            x2_q   <= '0;
            t2_q   <= '0;
            r3_q   <= '0;
            data_q <= '0;
            p1_q   <= '0;
            p2_q   <= '0;
            p3_q   <= '0;
            pass_q <= '0;
        end else if (advance) begin
            vld_q <= {vld_q[LAT-2:0], fire};
            if (fire) begin
                x1_q <= MUW'(in_a) * MUW'(in_w);
                p1_q <= in_pass;
            end
            if (vld_q[0]) begin
                x2_q <= x1_q;
                t2_q <= MUW'(xmu >> MUW);
                p2_q <= p1_q;
            end
            if (vld_q[1]) begin
                r3_q <= RW'(diff);
                p3_q <= p2_q;
            end
            if (vld_q[2]) begin
                data_q <= W'(red2);
                pass_q <= p3_q;
            end
        end
    end

endmodule

// File: tb/tb_ntt_barrett_modmul.sv
// Self-checking bench for ntt_barrett_modmul: vector table, scoreboarded streams,
// backpressure, configuration rejects and reset during mu computation.
module tb_ntt_barrett_modmul;
    localparam int W       = 16;
    localparam int PW      = 16;
    localparam int LAT_EXP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_load = 1'b0;
    logic [W-1:0]  cfg_q = '0;
    logic          cfg_busy, cfg_err, cfg_ready;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_w = '0;
    logic [PW-1:0] in_pass = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [PW-1:0] out_pass;

    always #5 clk = ~clk;

    ntt_barrett_modmul #(
        .W   (W),
        .PW  (PW),
        .LAT (LAT_EXP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_load  (cfg_load),
        .cfg_q     (cfg_q),
        .cfg_busy  (cfg_busy),
        .cfg_err   (cfg_err),
        .cfg_ready (cfg_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_w      (in_w),
        .in_pass   (in_pass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pass  (out_pass)
    );

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  w;
        logic [PW-1:0] pass;
        int unsigned   q;
        logic [W-1:0]  exp;
    } vec_t;

    typedef struct {
        logic [W-1:0]  data;
        logic [PW-1:0] pass;
    } sb_t;

    vec_t        tbl[8];
    sb_t         sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          n_out = 0;
    bit          mark_first = 1'b0;
    int unsigned cur_q = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every accepted result.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) begin
                if (mark_first) begin
                    first_cyc  = cyc;
                    mark_first = 1'b0;
                end
                last_cyc = cyc;
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", longint'(out_data), longint'(e.data));
                    check("out_pass", longint'(out_pass), longint'(e.pass));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] w,
                        input logic [PW-1:0] p, input logic [W-1:0] exp);
        sb_t e;
        int  n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_w     = w;
        in_pass  = p;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
        end else begin
            e.data = exp;
            e.pass = p;
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic wait_cfg(input int start_cnt, output int nbusy);
        nbusy = start_cnt;
        @(negedge clk);
        while (cfg_busy && nbusy < 200) begin
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic configure(input int unsigned q);
        int nb;
        cfg_load = 1'b1;
        cfg_q    = W'(q);
        tick();
        cfg_load = 1'b0;
        wait_cfg(0, nb);
        check("cfg_busy_cycles", nb, 2 * W + 1);
        check("cfg_ready_after_calc", longint'(cfg_ready), 1);
        check("mu_value", longint'(dut.mu_val), (64'd1 << (2 * W)) / q);
        cur_q = q;
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        tick();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        send(v.a, v.w, v.pass, v.exp);
        in_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, LAT_EXP);
        drain();
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] w,
                                           input int unsigned q);
        return W'((longint'(a) * longint'(w)) % longint'(q));
    endfunction

    initial begin
        int          nb;
        logic [W-1:0] a, w;

        tbl[0] = '{16'd200,   16'd200,   16'd7,      251,   16'd91};
        tbl[1] = '{16'd65535, 16'd65535, 16'd9,      251,   16'd74};
        tbl[2] = '{16'd250,   16'd250,   16'd3,      251,   16'd1};
        tbl[3] = '{16'd0,     16'd1234,  16'hBEEF,   251,   16'd0};
        tbl[4] = '{16'd1,     16'd1,     16'hFFFF,   251,   16'd1};
        tbl[5] = '{16'd12288, 16'd12288, 16'd1,      12289, 16'd1};
        tbl[6] = '{16'd65535, 16'd2,     16'd2,      12289, 16'd8180};
        tbl[7] = '{16'd3,     16'd4097,  16'd5,      12289, 16'd2};

        // Reset state
        #1;
        check("rst_cfg_busy", longint'(cfg_busy), 0);
        check("rst_cfg_ready", longint'(cfg_ready), 0);
        check("rst_cfg_err", longint'(cfg_err), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        tick();
        reset = 1'b1;
        tick();

        configure(251);
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].q == cur_q) run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Illegal modulus is rejected; configuration survives.
        cfg_load = 1'b1;
        cfg_q    = 16'd1;
        tick();
        cfg_load = 1'b0;
        @(negedge clk);
        check("badq_cfg_err", longint'(cfg_err), 1);
        check("badq_cfg_ready", longint'(cfg_ready), 1);
        check("badq_cfg_busy", longint'(cfg_busy), 0);
        @(negedge clk);
        check("badq_err_pulse", longint'(cfg_err), 0);
        tick();

        // Load and operand together on an empty pipeline: load wins.
        cfg_load = 1'b1;
        cfg_q    = 16'd12289;
        in_valid = 1'b1;
        in_a     = 16'd5;
        in_w     = 16'd6;
        in_pass  = 16'h0055;
        tick();
        cfg_load = 1'b0;
        @(negedge clk);
        check("simul_in_ready", longint'(in_ready), 0);
        check("simul_cfg_busy", longint'(cfg_busy), 1);
        check("simul_cfg_ready", longint'(cfg_ready), 0);
        in_valid = 1'b0;
        wait_cfg(1, nb);
        check("simul_busy_cycles", nb, 2 * W + 1);
        check("simul_cfg_ready_after", longint'(cfg_ready), 1);
        check("simul_mu", longint'(dut.mu_val), (64'd1 << (2 * W)) / 12289);
        cur_q = 12289;
        tick();

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].q == cur_q) run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back random stream
        mark_first = 1'b1;
        n_out      = 0;
        for (int i = 0; i < 32; i++) begin
            a = W'($urandom_range(0, 65535));
            w = W'($urandom_range(0, 65535));
            send(a, w, PW'(i), model(a, w, cur_q));
        end
        in_valid = 1'b0;
        drain();
        check("stream_count", n_out, 32);
        check("stream_no_gaps", last_cyc - first_cyc, 31);

        // Backpressure mid-stream
        for (int i = 0; i < 6; i++) begin
            a = W'($urandom_range(0, 65535));
            w = W'($urandom_range(0, 65535));
            send(a, w, PW'(16'h0100 + i), model(a, w, cur_q));
        end
        in_valid  = 1'b1;
        in_a      = 16'd4321;
        in_w      = 16'd8765;
        in_pass   = 16'hB00B;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", longint'(in_ready), 0);
            check("bp_out_valid", longint'(out_valid), 1);
            if (sb.size() != 0) begin
                check("bp_data_stable", longint'(out_data), longint'(sb[0].data));
                check("bp_pass_stable", longint'(out_pass), longint'(sb[0].pass));
            end
        end
        tick();
        out_ready = 1'b1;
        send(16'd4321, 16'd8765, 16'hB00B, model(16'd4321, 16'd8765, cur_q));
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom_range(0, 65535));
            w = W'($urandom_range(0, 65535));
            send(a, w, PW'(16'h0200 + i), model(a, w, cur_q));
        end
        in_valid = 1'b0;
        drain();

        // Load while data is in flight is rejected.
        send(16'd7, 16'd9, 16'h1111, 16'd63);
        in_valid = 1'b0;
        cfg_load = 1'b1;
        cfg_q    = 16'd251;
        tick();
        cfg_load = 1'b0;
        @(negedge clk);
        check("inflight_cfg_err", longint'(cfg_err), 1);
        check("inflight_cfg_ready", longint'(cfg_ready), 1);
        check("inflight_cfg_busy", longint'(cfg_busy), 0);
        @(negedge clk);
        check("inflight_err_pulse", longint'(cfg_err), 0);
        drain();
        check("inflight_q_unchanged", longint'(dut.mod_q), 12289);
        run_vec('{16'd12288, 16'd2, 16'h2222, 12289, 16'd12287}, "post_reject");

        // Reset during mu computation
        cfg_load = 1'b1;
        cfg_q    = 16'd251;
        tick();
        cfg_load = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_cfg_busy", longint'(cfg_busy), 0);
        check("midrst_cfg_ready", longint'(cfg_ready), 0);
        check("midrst_cfg_err", longint'(cfg_err), 0);
        check("midrst_in_ready", longint'(in_ready), 0);
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_out_data", longint'(out_data), 0);
        check("midrst_out_pass", longint'(out_pass), 0);
        check("midrst_mu", longint'(dut.mu_val), 0);
        check("midrst_q", longint'(dut.mod_q), 0);
        tick();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_a     = 16'd3;
        in_w     = 16'd3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("uncfg_in_ready", longint'(in_ready), 0);
            check("uncfg_cfg_ready", longint'(cfg_ready), 0);
            check("uncfg_cfg_busy", longint'(cfg_busy), 0);
        end
        in_valid = 1'b0;
        tick();
        configure(251);
        run_vec(tbl[0], "after_reset");

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
